// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl
//   Clock-enable sequencer for the MIPS register-file board design. A
//   free-running prescaler feeds a selectable rate source, and a small FSM
//   issues one-mclk-cycle tick enables in halt, free-run or single-step
//   mode. Downstream logic stays on mclk and qualifies with tick; no derived
//   clock leaves this block.
//
// Ports
//   mclk      in   system clock, all logic on the rising edge
//   clr_n     in   asynchronous active-low reset
//   mode      in   00 halt, 01/11 run, 10 single step
//   rate_sel  in   0..2 pick prescaler bit RATE0/1/2_BIT, 3 = every cycle
//   step_btn  in   raw asynchronous push-button, active-high
//   tick      out  one-cycle clock-enable pulse (registered)
//   tick_cnt  out  count of issued ticks, wraps
//   state     out  FSM encoding for LEDs / debug
//   btn_db    out  debounced button level
module clk_step_ctrl #(
  parameter int CNT_W      = 28,
  parameter int RATE0_BIT  = 24,
  parameter int RATE1_BIT  = 18,
  parameter int RATE2_BIT  = 16,
  parameter int DEB_CYCLES = 250000,
  parameter int TCNT_W     = 16
) (
  input  logic              mclk,
  input  logic              clr_n,
  input  logic [1:0]        mode,
  input  logic [1:0]        rate_sel,
  input  logic              step_btn,
  output logic              tick,
  output logic [TCNT_W-1:0] tick_cnt,
  output logic [2:0]        state,
  output logic              btn_db
);

  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [2:0] {
    HALT      = 3'd0,
    RUN       = 3'd1,
    STEP_ARM  = 3'd2,
    STEP_FIRE = 3'd3,
    STEP_HOLD = 3'd4
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] q;
  logic [1:0]       rate_sel_q;
  logic             src_prev;
  logic             src_bit;
  logic             rate_chg;
  logic             src_ev;
  logic             btn_s1, btn_s2;
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_db_q;
  logic             press;

  // Prescaler bits above the slowest tap are intentionally unobserved.
  logic unused_q;
  assign unused_q = ^q;

  // Rate tap selection. Rate 3 does not use a tap; the edge detector is
  // simply bypassed.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    src_bit = 1'b0;
    case (rate_sel)
      2'd0:    src_bit = q[RATE0_BIT];
      2'd1:    src_bit = q[RATE1_BIT];
      2'd2:    src_bit = q[RATE2_BIT];
      default: src_bit = 1'b0;
    endcase
  end

  // A rate change suppresses the event for one cycle so the new tap's
  // current level is never mistaken for a rising edge.
  assign rate_chg = (rate_sel != rate_sel_q);
  assign src_ev   = !rate_chg && ((rate_sel == 2'd3) || (src_bit && !src_prev));

  // Prescaler and rate-edge detector.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      q          <= '0;
      src_prev   <= 1'b0;
      rate_sel_q <= 2'd0;
    end else begin
      q          <= q + CNT_W'(1);
      src_prev   <= src_bit;
      rate_sel_q <= rate_sel;
    end
  end

  // Button: 2-FF synchroniser, level debouncer, rising-edge press pulse.
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      deb_cnt  <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      btn_s1   <= step_btn;
      btn_s2   <= btn_s1;
      btn_db_q <= btn_db;
      press    <= btn_db && !btn_db_q;
      if (btn_s2 == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        btn_db  <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Mode FSM with registered tick and tick counter. Mode decoding comes
  // first so a mode change wins over any step transition in the same cycle.
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      st       <= HALT;
      tick     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      // mode[0] is re-checked so the cycle that leaves run never ticks.
      tick     <= ((st == RUN) && src_ev && mode[0]) || (st == STEP_FIRE);
      tick_cnt <= tick_cnt + TCNT_W'(tick);
      if (mode == 2'b00) begin
        st <= HALT;
      end else if (mode[0]) begin
        st <= RUN;
      end else begin
        case (st)
          HALT, RUN: st <= btn_db ? STEP_HOLD : STEP_ARM; // held button never fires
          STEP_ARM:  if (press) st <= STEP_FIRE;
          STEP_FIRE: st <= STEP_HOLD;
          STEP_HOLD: if (!btn_db) st <= STEP_ARM;
          default:   st <= HALT;
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl
//   Directed bench for clk_step_ctrl with shrunk parameters: 8-bit
//   prescaler, rate taps 6/4/2, 4-sample debounce, 4-bit tick counter.
module tb_clk_step_ctrl;

  localparam int TCNT_W = 4;

  logic              mclk = 1'b0;
  logic              clr_n;
  logic [1:0]        mode;
  logic [1:0]        rate_sel;
  logic              step_btn;
  logic              tick;
  logic [TCNT_W-1:0] tick_cnt;
  logic [2:0]        state;
  logic              btn_db;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ticks  = 0;
  int t0;

  clk_step_ctrl #(
    .CNT_W     (8),
    .RATE0_BIT (6),
    .RATE1_BIT (4),
    .RATE2_BIT (2),
    .DEB_CYCLES(4),
    .TCNT_W    (TCNT_W)
  ) dut (
    .mclk    (mclk),
    .clr_n   (clr_n),
    .mode    (mode),
    .rate_sel(rate_sel),
    .step_btn(step_btn),
    .tick    (tick),
    .tick_cnt(tick_cnt),
    .state   (state),
    .btn_db  (btn_db)
  );

  always #5 mclk = ~mclk;

  // Independent tick tally, sampled mid-cycle.
  always @(negedge mclk) if (clr_n === 1'b1 && tick === 1'b1) n_ticks++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle; sample point is 1 ns after the rising edge.
  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      if (state === exp) break;
      cyc();
    end
    check(tag, {29'd0, state}, {29'd0, exp});
  endtask

  // Clean press from STEP_ARM: exactly one tick, then release back to ARM.
  task automatic do_press(input logic [TCNT_W-1:0] exp_cnt, input string tag);
    int t_start;
    t_start  = n_ticks;
    step_btn = 1'b1;
    wait_state(3'd3, 15, {tag, "_fire"});
    cyc();
    check({tag, "_hold"}, {29'd0, state}, 32'd4);
    check({tag, "_tick"}, {31'd0, tick}, 32'd1);
    cyc();
    check({tag, "_tick_end"}, {31'd0, tick}, 32'd0);
    check({tag, "_cnt"}, {28'd0, tick_cnt}, {28'd0, exp_cnt});
    repeat (12) cyc();
    step_btn = 1'b0;
    wait_state(3'd2, 20, {tag, "_rearm"});
    check({tag, "_one_tick"}, n_ticks - t_start, 32'd1);
  endtask

  initial begin
    // Reset held with run mode and button pressed: everything stays clear.
    clr_n    = 1'b0;
    mode     = 2'b01;
    rate_sel = 2'd2;
    step_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_tick", {31'd0, tick}, 32'd0);
      check("rst_cnt", {28'd0, tick_cnt}, 32'd0);
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_btn_db", {31'd0, btn_db}, 32'd0);
    end
    step_btn = 1'b0;
    @(negedge mclk);
    clr_n = 1'b1;

    // Free run on q[2]: first rise at q=4 -> tick after edge 5, then every 8.
    for (int k = 1; k <= 64; k++) begin
      cyc();
      check($sformatf("run_tick_%0d", k), {31'd0, tick}, {31'd0, (k % 8) == 5});
    end
    check("run_cnt", {28'd0, tick_cnt}, 32'd8);
    check("run_state", {29'd0, state}, 32'd1);

    // Switch to q[6] while q[6]=1 and the old detector history is 0.
    cyc();
    check("pre_chg_tick", {31'd0, tick}, 32'd0);
    rate_sel = 2'd0;
    cyc();
    check("chg_no_tick", {31'd0, tick}, 32'd0);
    t0 = n_ticks;
    repeat (126) cyc();
    check("chg_quiet", n_ticks - t0, 32'd0);
    cyc();
    check("rate0_tick", {31'd0, tick}, 32'd1);

    // Enter step mode with the button released.
    mode = 2'b10;
    cyc();
    check("step_arm", {29'd0, state}, 32'd2);
    check("step_cnt9", {28'd0, tick_cnt}, 32'd9);
    check("step_no_tick", {31'd0, tick}, 32'd0);

    // Two-cycle glitches are rejected by the debouncer.
    t0 = n_ticks;
    for (int g = 0; g < 2; g++) begin
      step_btn = 1'b1;
      cyc();
      cyc();
      step_btn = 1'b0;
      repeat (8) cyc();
    end
    check("glitch_btn_db", {31'd0, btn_db}, 32'd0);
    check("glitch_state", {29'd0, state}, 32'd2);
    check("glitch_ticks", n_ticks - t0, 32'd0);

    do_press(4'd10, "press1");

    // Entering step mode with the button already held must not fire.
    mode = 2'b00;
    cyc();
    check("halt_state", {29'd0, state}, 32'd0);
    step_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (btn_db === 1'b1) break;
      cyc();
    end
    check("held_btn_db", {31'd0, btn_db}, 32'd1);
    t0   = n_ticks;
    mode = 2'b10;
    cyc();
    check("held_entry", {29'd0, state}, 32'd4);
    repeat (10) cyc();
    check("held_stay", {29'd0, state}, 32'd4);
    step_btn = 1'b0;
    wait_state(3'd2, 20, "held_release");
    check("held_no_tick", n_ticks - t0, 32'd0);
    check("held_cnt", {28'd0, tick_cnt}, 32'd10);

    do_press(4'd11, "press2");

    // Every-cycle rate: back-to-back ticks, counter wraps 15 -> 0 -> 1.
    mode     = 2'b01;
    rate_sel = 2'd3;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      check($sformatf("wrap_tick_%0d", k), {31'd0, tick}, {31'd0, k >= 2});
      check($sformatf("wrap_cnt_%0d", k), {28'd0, tick_cnt},
            (32'd11 + ((k > 2) ? 32'(k - 2) : 32'd0)) & 32'hF);
    end

    // Asynchronous clear between clock edges.
    #2;
    clr_n = 1'b0;
    #1;
    check("async_tick", {31'd0, tick}, 32'd0);
    check("async_cnt", {28'd0, tick_cnt}, 32'd0);
    check("async_state", {29'd0, state}, 32'd0);
    @(negedge mclk);
    clr_n = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
